// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: raster scan of a flat 8-bit image bus, |Gx|+|Gy| vs threshold, 1-bit edge map.
// Optional build macro SOBEL_BORDER_REPLICATE_EN computes border pixels with clamped neighbours.
module sobel_edge_detector #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               threshold,
  input  logic [WIDTH*DEPTH*8:0]   inputImage,
  output logic [WIDTH*DEPTH:0]     bmpOutput,
  output logic                     frame_done
);

  localparam int NPIX = WIDTH * DEPTH;
  localparam int IW   = $clog2(NPIX);
  localparam int RW   = $clog2(DEPTH);
  localparam int CW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_PIX = IW'(NPIX - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  logic [IW-1:0] r_cnt;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  logic [RW-1:0]     w_nrow [3];
  logic [CW-1:0]     w_ncol [3];
  logic [11:0]       w_p    [9];
  logic signed [11:0] w_gx, w_gy;
  logic              w_border;

  logic signed [11:0] r_gx, r_gy;
  logic [IW-1:0]     r_idx;
  logic              r_border;
  logic              r_valid;

  logic [11:0]       w_ax, w_ay;
  logic [10:0]       w_mag;
  logic              w_edge;

  logic [NPIX-1:0]   r_bmp;
  logic              r_frame_done;
  logic              w_unused;

  // Row/column are tracked alongside the flat index so no divider is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (r_cnt == LAST_PIX) begin
      r_cnt <= '0;
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Neighbour indices are clamped in both builds so the bus is never read out of range.
  always_comb begin
    // NOTE: every element of the arrays is assigned on every evaluation, so no latch is inferred.
    w_nrow[0] = (r_row == '0)      ? r_row : r_row - 1'b1;
    w_nrow[1] = r_row;
    w_nrow[2] = (r_row == LAST_ROW) ? r_row : r_row + 1'b1;
    w_ncol[0] = (r_col == '0)      ? r_col : r_col - 1'b1;
    w_ncol[1] = r_col;
    w_ncol[2] = (r_col == LAST_COL) ? r_col : r_col + 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_p[3*i+j] = {4'b0, inputImage[(int'(w_nrow[i]) * WIDTH + int'(w_ncol[j])) * 8 +: 8]};
      end
    end
  end

  assign w_gx = $signed((w_p[2] + (w_p[5] << 1) + w_p[8]) - (w_p[0] + (w_p[3] << 1) + w_p[6]));
  assign w_gy = $signed((w_p[6] + (w_p[7] << 1) + w_p[8]) - (w_p[0] + (w_p[1] << 1) + w_p[2]));

`ifdef SOBEL_BORDER_REPLICATE_EN
  assign w_border = 1'b0;
`else
  assign w_border = (r_row == '0) || (r_row == LAST_ROW) || (r_col == '0) || (r_col == LAST_COL);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gx     <= '0;
      r_gy     <= '0;
      r_idx    <= '0;
      r_border <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_gx     <= w_gx;
      r_gy     <= w_gy;
      r_idx    <= r_cnt;
      r_border <= w_border;
      r_valid  <= 1'b1;
    end
  end

  assign w_ax   = r_gx[11] ? $unsigned(-r_gx) : $unsigned(r_gx);
  assign w_ay   = r_gy[11] ? $unsigned(-r_gy) : $unsigned(r_gy);
  assign w_mag  = 11'(w_ax + w_ay);
  assign w_edge = !r_border && (w_mag > {3'b0, threshold});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the edge map is a flop vector, not a RAM, so it is cleared by the async reset like any other state.
      r_bmp        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_valid && (r_idx == LAST_PIX);
      if (r_valid) r_bmp[r_idx] <= w_edge;
    end
  end

  assign w_unused   = inputImage[NPIX*8];
  assign bmpOutput  = {1'b0, r_bmp};
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed bench for sobel_edge_detector on an 8x8 image; expectations follow SOBEL_BORDER_REPLICATE_EN.
module tb_sobel_edge_detector;

  localparam int W = 8;
  localparam int D = 8;
  localparam int N = W * D;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   threshold = '0;
  logic [N*8:0] inputImage = '0;
  logic [N:0]   bmpOutput;
  logic         frame_done;

  int n_vec = 0;
  int n_err = 0;

  sobel_edge_detector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .threshold  (threshold),
    .inputImage (inputImage),
    .bmpOutput  (bmpOutput),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Columns 0-3 take lo, columns 4-7 take hi; the ignored MSB is set to prove it is ignored.
  function automatic logic [N*8:0] make_img(input logic [7:0] lo, input logic [7:0] hi);
    logic [N*8:0] img;
    img = '0;
    for (int k = 0; k < N; k++) img[8*k +: 8] = ((k % W) < 4) ? lo : hi;
    img[N*8] = 1'b1;
    return img;
  endfunction

  // Step edge lands on columns 3 and 4; border rows only count in the replicate build.
  function automatic logic [N:0] step_map();
    logic [N:0] m;
    m = '0;
    for (int r = 1; r < D - 1; r++) begin
      m[r*W+3] = 1'b1;
      m[r*W+4] = 1'b1;
    end
`ifdef SOBEL_BORDER_REPLICATE_EN
    m[3] = 1'b1;          m[4] = 1'b1;
    m[(D-1)*W+3] = 1'b1;  m[(D-1)*W+4] = 1'b1;
`endif
    return m;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inputImage = make_img(8'd0, 8'd255);
    threshold  = 8'd0;
    run_edges(2);
    n_vec++;
    if (bmpOutput !== '0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state bmp=%h fd=%b want bmp=0 fd=0", bmpOutput, frame_done);
    end
  endtask

  task automatic test_uniform();
    inputImage = make_img(8'd100, 8'd100);
    threshold  = 8'd51;
    do_reset();
    for (int e = 1; e <= 130; e++) begin
      @(negedge clk);
      n_vec++;
      if (frame_done !== ((e == 65) || (e == 129))) begin
        n_err++;
        $display("FAIL uniform_frame_done edge=%0d got=%b want=%b", e, frame_done, (e == 65) || (e == 129));
      end
    end
    n_vec++;
    if (bmpOutput !== '0) begin
      n_err++;
      $display("FAIL uniform_map got=%h want=0", bmpOutput);
    end
  endtask

  task automatic test_step();
    inputImage = make_img(8'd0, 8'd200);
    threshold  = 8'd51;
    do_reset();
    run_edges(65);
    n_vec++;
    if (bmpOutput !== step_map()) begin
      n_err++;
      $display("FAIL step_map got=%h want=%h", bmpOutput, step_map());
    end
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL step_frame_done got=%b want=1", frame_done);
    end
  endtask

  task automatic test_threshold();
    inputImage = make_img(8'd0, 8'd60);
    threshold  = 8'd240;
    do_reset();
    run_edges(65);
    n_vec++;
    if (bmpOutput !== '0) begin
      n_err++;
      $display("FAIL thresh_equal got=%h want=0", bmpOutput);
    end
    threshold = 8'd239;
    run_edges(64);
    n_vec++;
    if (bmpOutput !== step_map()) begin
      n_err++;
      $display("FAIL thresh_below got=%h want=%h", bmpOutput, step_map());
    end
  endtask

  // The centre pixel is not part of its own kernel, so bit 27 stays 0; its eight neighbours see 255.
  task automatic test_latency();
    int nb [8] = '{18, 19, 20, 26, 28, 34, 35, 36};
    logic [N:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) mask[nb[i]] = 1'b1;
    inputImage = '0;
    inputImage[8*27 +: 8] = 8'd255;
    threshold = 8'd0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (e == nb[i] + 1 || e == nb[i] + 2) begin
          n_vec++;
          if (bmpOutput[nb[i]] !== (e == nb[i] + 2)) begin
            n_err++;
            $display("FAIL latency bit=%0d edge=%0d got=%b want=%b", nb[i], e, bmpOutput[nb[i]], e == nb[i] + 2);
          end
        end
      end
      if (e == 29) begin
        n_vec++;
        if (bmpOutput[27] !== 1'b0) begin
          n_err++;
          $display("FAIL latency_centre got=%b want=0", bmpOutput[27]);
        end
      end
    end
    n_vec++;
    if (bmpOutput !== mask) begin
      n_err++;
      $display("FAIL latency_map got=%h want=%h", bmpOutput, mask);
    end
  endtask

  task automatic test_reset_mid_frame();
    inputImage = make_img(8'd0, 8'd200);
    threshold  = 8'd51;
    do_reset();
    run_edges(30);
    n_vec++;
    if (bmpOutput[11] !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre bit11 got=%b want=1", bmpOutput[11]);
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (bmpOutput !== '0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear bmp=%h fd=%b want bmp=0 fd=0", bmpOutput, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      @(negedge clk);
      n_vec++;
      if (frame_done !== (e == 65)) begin
        n_err++;
        $display("FAIL midreset_frame_done edge=%0d got=%b want=%b", e, frame_done, e == 65);
      end
      if (e == 11 || e == 12 || e == 13) begin
        n_vec++;
        if (bmpOutput[11] !== (e == 13) || bmpOutput[9] !== 1'b0) begin
          n_err++;
          $display("FAIL midreset_restart edge=%0d bit11=%b bit9=%b want bit11=%b bit9=0",
                   e, bmpOutput[11], bmpOutput[9], e == 13);
        end
      end
    end
  endtask

  // Pixels 40 and up are fetched after the switch; earlier pixels keep the uniform result.
  task automatic test_live_change();
    logic [N:0] exp;
    exp = step_map();
    for (int k = 0; k < 40; k++) exp[k] = 1'b0;
    inputImage = make_img(8'd100, 8'd100);
    threshold  = 8'd51;
    do_reset();
    run_edges(40);
    inputImage = make_img(8'd0, 8'd200);
    run_edges(25);
    n_vec++;
    if (bmpOutput !== exp) begin
      n_err++;
      $display("FAIL live_partial got=%h want=%h", bmpOutput, exp);
    end
    run_edges(64);
    n_vec++;
    if (bmpOutput !== step_map()) begin
      n_err++;
      $display("FAIL live_next_frame got=%h want=%h", bmpOutput, step_map());
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_step();
    test_threshold();
    test_latency();
    test_reset_mid_frame();
    test_live_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
